// File: rtl/dc_ipu_texel_fetch_gen.sv
// Texel fetch generator: clamps the two neighbouring texel indices of each
// sample to the texture edge, requests only the texels missing from a
// 2-texel sliding window, and emits a shift/fraction token for the
// horizontal interpolator.
//
// state | meaning
// IDLE  | waiting for a sample (in_ready=1)
// REQ0  | requesting texel i0
// REQ1  | requesting texel i1
// TOK   | presenting interpolator token
module dc_ipu_texel_fetch_gen #(
    parameter int TEX_SIZE_WIDTH  = 12,
    parameter int TEX_FRACT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sol,
    input  logic [TEX_SIZE_WIDTH-1:0]  tex_addr,
    input  logic [TEX_FRACT_WIDTH-1:0] tex_addr_fract,
    input  logic [TEX_SIZE_WIDTH-1:0]  tex_size,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [TEX_SIZE_WIDTH-1:0]  req_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TEX_FRACT_WIDTH-1:0] out_fract,
    output logic [1:0]                 out_shift
);

    localparam int AW = TEX_SIZE_WIDTH + 2;
    localparam logic signed [AW-1:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ0, S_REQ1, S_TOK} state_t;

    state_t                     state_q, state_d;
    logic [TEX_SIZE_WIDTH-1:0]  i0_q, i1_q;
    logic [TEX_FRACT_WIDTH-1:0] fract_q;
    logic [1:0]                 nshift_q;
    logic                       wvalid_q;

    logic signed [AW-1:0]       addr_s, addr1_s, max_s;
    logic [TEX_SIZE_WIDTH-1:0]  i0_c, i1_c;
    logic [1:0]                 nshift_c;
    logic                       accept;

    assign accept = in_valid && in_ready;

    // Clamp both neighbour indices; a zero-sized texture behaves as size 1.
    always_comb begin
        addr_s  = {{2{tex_addr[TEX_SIZE_WIDTH-1]}}, tex_addr};
        addr1_s = addr_s + ONE;
        max_s   = (tex_size == '0) ? '0 : $signed({2'b00, tex_size}) - ONE;
        i0_c    = '0;
        i1_c    = '0;
        if (addr_s >= 0)
            i0_c = (addr_s > max_s) ? max_s[TEX_SIZE_WIDTH-1:0] : addr_s[TEX_SIZE_WIDTH-1:0];
        if (addr1_s >= 0)
            i1_c = (addr1_s > max_s) ? max_s[TEX_SIZE_WIDTH-1:0] : addr1_s[TEX_SIZE_WIDTH-1:0];
    end

    // Window comparison; the latched indices of the last sample are the window.
    always_comb begin
        nshift_c = 2'd2;
        if (!wvalid_q || in_sol)
            nshift_c = 2'd2;
        else if (i0_c == i0_q && i1_c == i1_q)
            nshift_c = 2'd0;
        else if (i0_c == i1_q)
            nshift_c = 2'd1;
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; clr overrides any handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (nshift_c)
                    2'd0:    state_d = S_TOK;
                    2'd1:    state_d = S_REQ1;
                    default: state_d = S_REQ0;
                endcase
            end
            S_REQ0: if (req_ready) state_d = S_REQ1;
            S_REQ1: if (req_ready) state_d = S_TOK;
            S_TOK:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clr)
            state_d = S_IDLE;
    end

    // Sample and window registers, captured at accept.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            i0_q     <= '0;
            i1_q     <= '0;
            fract_q  <= '0;
            nshift_q <= '0;
            wvalid_q <= 1'b0;
        end else if (clr) begin
            i0_q     <= '0;
            i1_q     <= '0;
            fract_q  <= '0;
            nshift_q <= '0;
            wvalid_q <= 1'b0;
        end else if (accept) begin
            i0_q     <= i0_c;
            i1_q     <= i1_c;
            fract_q  <= tex_addr_fract;
            nshift_q <= nshift_c;
            wvalid_q <= 1'b1;
        end
    end

    // Outputs decoded from state; data held in registers keeps them stable.
    always_comb begin
        in_ready  = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        out_valid = 1'b0;
        out_fract = '0;
        out_shift = '0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_REQ0: begin
                req_valid = 1'b1;
                req_addr  = i0_q;
            end
            S_REQ1: begin
                req_valid = 1'b1;
                req_addr  = i1_q;
            end
            S_TOK: begin
                out_valid = 1'b1;
                out_fract = fract_q;
                out_shift = nshift_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dc_ipu_texel_fetch_gen.sv
// Bench for dc_ipu_texel_fetch_gen: directed samples with expected requests
// and tokens queued at drive time and checked as the DUT hands them off.
module tb_dc_ipu_texel_fetch_gen;

    logic        clk = 1'b0;
    logic        nreset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic        in_sol;
    logic [11:0] tex_addr;
    logic [7:0]  tex_addr_fract;
    logic [11:0] tex_size;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_fract;
    logic [1:0]  out_shift;

    typedef struct {
        logic [7:0] fract;
        logic [1:0] shift;
        int         lat;
    } tok_t;

    logic [11:0] req_q[$];
    tok_t        tok_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    dc_ipu_texel_fetch_gen #(
        .TEX_SIZE_WIDTH(12),
        .TEX_FRACT_WIDTH(8)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sol(in_sol),
        .tex_addr(tex_addr),
        .tex_addr_fract(tex_addr_fract),
        .tex_size(tex_size),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_fract(out_fract),
        .out_shift(out_shift)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (in_valid && in_ready)
            acc_cyc = cyc;
        if (req_valid && req_ready) begin
            chk("req_expected", req_q.size() > 0, 1);
            if (req_q.size() > 0)
                chk("req_addr", req_addr, req_q.pop_front());
        end
        if (out_valid && out_ready) begin
            chk("tok_expected", tok_q.size() > 0, 1);
            if (tok_q.size() > 0) begin
                tok_t t;
                t = tok_q.pop_front();
                chk("tok_fract", out_fract, t.fract);
                chk("tok_shift", out_shift, t.shift);
                if (t.lat >= 0)
                    chk("tok_latency", cyc - acc_cyc, t.lat);
            end
        end
    end

    task automatic send(input logic signed [11:0] a, input logic [7:0] f, input logic sol,
                        input logic [1:0] sh, input int lat, input int nreq,
                        input logic [11:0] r0, input logic [11:0] r1);
        bit ok;
        tok_t t;
        if (nreq == 1) req_q.push_back(r0);
        if (nreq == 2) begin
            req_q.push_back(r0);
            req_q.push_back(r1);
        end
        t.fract = f;
        t.shift = sh;
        t.lat   = lat;
        tok_q.push_back(t);
        tex_addr       = a;
        tex_addr_fract = f;
        in_sol         = sol;
        in_valid       = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_q.size() != 0 || tok_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_timeout", n < 60, 1);
    endtask

    initial begin
        nreset = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_sol = 1'b0;
        tex_addr = '0;
        tex_addr_fract = '0;
        tex_size = 12'd4;
        req_ready = 1'b1;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_out_fract", out_fract, 0);
        chk("rst_out_shift", out_shift, 0);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Upscale line, size 4.
        send(-1, 8'd192, 1, 2'd2, 3, 2, 12'd0, 12'd0); drain();
        send(0,  8'd64,  0, 2'd1, 2, 1, 12'd1, 12'd0); drain();
        send(0,  8'd192, 0, 2'd0, 1, 0, 12'd0, 12'd0); drain();
        send(1,  8'd64,  0, 2'd1, 2, 1, 12'd2, 12'd0); drain();

        // Right edge.
        send(2, 8'd10,  0, 2'd1, 2, 1, 12'd3, 12'd0); drain();
        send(3, 8'd64,  0, 2'd1, 2, 1, 12'd3, 12'd0); drain();
        send(3, 8'd192, 0, 2'd0, 1, 0, 12'd0, 12'd0); drain();

        // Backpressure on requests, then on the token.
        req_ready = 1'b0;
        send(0, 8'd100, 1, 2'd2, -1, 2, 12'd0, 12'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_valid", req_valid, 1);
            chk("bp_req_addr", req_addr, 12'd0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        req_ready = 1'b1;
        out_ready = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            chk("bp_tok_timeout", out_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_shift", out_shift, 2'd2);
            chk("bp_out_fract", out_fract, 8'd100);
            chk("bp_in_ready_tok", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_single_token", out_valid, 0);
        @(posedge clk);
        #1;

        // Line restart.
        send(1, 8'd50, 0, 2'd1, 2, 1, 12'd2, 12'd0); drain();
        send(1, 8'd0,  1, 2'd2, 3, 2, 12'd1, 12'd2); drain();
        send(1, 8'd0,  0, 2'd0, 1, 0, 12'd0, 12'd0); drain();

        // Synchronous clear in REQ1.
        req_ready = 1'b0;
        send(2, 8'd7, 1, 2'd2, -1, 2, 12'd2, 12'd3);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        @(negedge clk);
        chk("clr_pre_req_addr", req_addr, 12'd3);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_req_valid", req_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        req_q.delete();
        tok_q.delete();
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'd0, 0, 2'd2, 3, 2, 12'd0, 12'd1); drain();

        // Same sequence with asynchronous reset.
        req_ready = 1'b0;
        send(2, 8'd7, 1, 2'd2, -1, 2, 12'd2, 12'd3);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        @(negedge clk);
        chk("rst_pre_req_addr", req_addr, 12'd3);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        #2;
        chk("arst_req_valid", req_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        #1;
        nreset = 1'b1;
        req_q.delete();
        tok_q.delete();
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'd0, 0, 2'd2, 3, 2, 12'd0, 12'd1); drain();

        // Degenerate sizes.
        tex_size = 12'd0;
        send(5, 8'd10, 1, 2'd2, 3, 2, 12'd0, 12'd0); drain();
        tex_size = 12'd1;
        send(-3, 8'd33, 1, 2'd2, 3, 2, 12'd0, 12'd0); drain();
        send(7,  8'd44, 0, 2'd0, 1, 0, 12'd0, 12'd0); drain();

        chk("end_req_q_empty", req_q.size(), 0);
        chk("end_tok_q_empty", tok_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
